// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Instruction fetch front end feeding the Core's decode stage. It walks
// sequential fetch addresses, keeps at most one request outstanding to
// instruction memory, and buffers returned words together with their PCs in a
// small circular prefetch FIFO. The Core drains the FIFO over a valid/ready
// handshake. A redirect flushes the FIFO, restarts fetching at the new PC and
// discards the response of any request that is still in flight.
//
// Ports:
//   CLK          clock, all state changes on the rising edge
//   RESET_N      asynchronous active-low reset
//   IMEM_REQ     request to instruction memory (registered)
//   IMEM_ADDR    request address, held until IMEM_ACK (registered)
//   IMEM_ACK     memory completes the outstanding request this cycle
//   IMEM_RDATA   instruction word, valid with IMEM_ACK
//   REDIRECT     Core restarts fetching (taken branch / jump)
//   REDIRECT_PC  restart address, bits [1:0] are ignored
//   INSTR_VALID  FIFO head holds an instruction
//   INSTR        head instruction word
//   INSTR_PC     PC of the head instruction
//   INSTR_READY  Core consumes the head when INSTR_VALID & INSTR_READY
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic              IMEM_ACK,
    input  logic [31:0]       IMEM_RDATA,
    input  logic              REDIRECT,
    input  logic [ADDR_W-1:0] REDIRECT_PC,
    output logic              INSTR_VALID,
    output logic [31:0]       INSTR,
    output logic [ADDR_W-1:0] INSTR_PC,
    input  logic              INSTR_READY
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_KILL = 2'd2
    } state_e;

    state_e             state_q,    state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic               req_q,      req_d;
    logic [ADDR_W-1:0]  addr_q,     addr_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic [PTR_W-1:0]   head_q,     head_d;
    logic [PTR_W-1:0]   tail_q,     tail_d;

    logic [31:0]        instr_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

    logic               pop_s;
    logic               push_s;
    logic               space_idle_s;
    logic               space_wait_s;
    logic [ADDR_W-1:0]  redirect_pc_s;
    logic [ADDR_W-1:0]  pc_inc_s;

    // FIFO bookkeeping and fetch FSM next-state logic
    always_comb begin
        // A pop coinciding with a redirect is swallowed by the flush.
        pop_s         = (count_q != {CNT_W{1'b0}}) & INSTR_READY & ~REDIRECT;
        push_s        = (state_q == ST_WAIT) & IMEM_ACK & ~REDIRECT;
        // Room for a new request once this cycle's pop has been accounted.
        space_idle_s  = (count_q - CNT_W'(pop_s)) < DEPTH_C;
        // In WAIT the acked word also takes a slot before the next request.
        space_wait_s  = (count_q + CNT_W'(1'b1) - CNT_W'(pop_s)) < DEPTH_C;
        redirect_pc_s = REDIRECT_PC & ~(ADDR_W'(2'd3));
        pc_inc_s      = fetch_pc_q + ADDR_W'(3'd4);

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;

        if (REDIRECT) begin
            count_d = {CNT_W{1'b0}};
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
        end else begin
            count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
            head_d  = pop_s  ? head_q + PTR_W'(1'b1) : head_q;
            tail_d  = push_s ? tail_q + PTR_W'(1'b1) : tail_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (REDIRECT) begin
                    // New request waits one edge so the flush settles first.
                    fetch_pc_d = redirect_pc_s;
                end else if (space_idle_s) begin
                    state_d    = ST_WAIT;
                    req_d      = 1'b1;
                    addr_d     = fetch_pc_q;
                    fetch_pc_d = pc_inc_s;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (REDIRECT) begin
                    fetch_pc_d = redirect_pc_s;
                    if (IMEM_ACK) begin
                        state_d = ST_IDLE;
                        req_d   = 1'b0;
                    end else begin
                        // Request stays up; its response will be dropped.
                        state_d = ST_KILL;
                    end
                end else if (IMEM_ACK) begin
                    if (space_wait_s) begin
                        addr_d     = fetch_pc_q;
                        fetch_pc_d = pc_inc_s;
                    end else begin
                        state_d = ST_IDLE;
                        req_d   = 1'b0;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_KILL: begin
                if (REDIRECT) begin
                    fetch_pc_d = redirect_pc_s;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                if (IMEM_ACK) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end else begin
                    state_d = ST_KILL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            count_q    <= {CNT_W{1'b0}};
            head_q     <= {PTR_W{1'b0}};
            tail_q     <= {PTR_W{1'b0}};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Prefetch FIFO storage, written at the tail on each accepted response
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= 32'h0000_0000;
                pc_mem_q[i]    <= {ADDR_W{1'b0}};
            end
        end else if (push_s) begin
            instr_mem_q[tail_q] <= IMEM_RDATA;
            pc_mem_q[tail_q]    <= addr_q;
        end else begin
            instr_mem_q[tail_q] <= instr_mem_q[tail_q];
            pc_mem_q[tail_q]    <= pc_mem_q[tail_q];
        end
    end

    assign IMEM_REQ    = req_q;
    assign IMEM_ADDR   = addr_q;
    assign INSTR_VALID = (count_q != {CNT_W{1'b0}});
    assign INSTR       = instr_mem_q[head_q];
    assign INSTR_PC    = pc_mem_q[head_q];

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Instruction fetch front end sitting directly upstream of the Core's decode stage.
- Generates sequential fetch addresses and issues single-outstanding requests to instruction memory.
- Buffers returned instructions with their PCs in a small prefetch FIFO and presents them to the Core on a valid/ready handshake.
- Honours branch/jump redirects by flushing queued and in-flight instructions.

Parameters:
- ADDR_W, 32, width of fetch addresses and PCs.
- DEPTH, 4, prefetch FIFO entries (power of two, >= 2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IMEM_REQ  out  1  fetch request to instruction memory.
- IMEM_ADDR  out  ADDR_W  fetch address; stable while IMEM_REQ high.
- IMEM_ACK  in  1  memory completed the request this cycle.
- IMEM_RDATA  in  32  instruction word; valid when IMEM_ACK=1.
- REDIRECT  in  1  Core requests a fetch restart (taken branch/jump).
- REDIRECT_PC  in  ADDR_W  restart address; sampled when REDIRECT=1.
- INSTR_VALID  out  1  FIFO head holds a valid instruction.
- INSTR  out  32  head instruction word.
- INSTR_PC  out  ADDR_W  PC of the head instruction.
- INSTR_READY  in  1  Core consumes head when INSTR_VALID & INSTR_READY.

Behaviour:
- Reset (RESET_N=0, immediate): state=IDLE, fetch_pc=RESET_PC, count=0, IMEM_REQ=0, IMEM_ADDR=RESET_PC, INSTR_VALID=0, INSTR=0, INSTR_PC=0.
- Reset asserted mid-request abandons the request. Memory must accept IMEM_REQ dropping without an ack.
- Memory protocol:
  - At most one request outstanding.
  - IMEM_REQ and IMEM_ADDR are registered and held until IMEM_ACK is sampled high.
  - Ack may arrive in any cycle while IMEM_REQ=1, including the first.
- pop = INSTR_VALID & INSTR_READY & ~REDIRECT.
- push = IMEM_ACK in WAIT & ~REDIRECT.
- space = (count - pop) < DEPTH.
- FSM states:
  - IDLE: no request outstanding. If ~REDIRECT and space: next edge enters WAIT with IMEM_REQ=1, IMEM_ADDR=fetch_pc, fetch_pc+=4.
  - WAIT: request outstanding, response wanted.
    - On IMEM_ACK: write {IMEM_RDATA, IMEM_ADDR} at FIFO tail.
    - If (count+1-pop) < DEPTH, issue the next request on the same edge (stay WAIT, IMEM_ADDR=fetch_pc, fetch_pc+=4). Otherwise go to IDLE with IMEM_REQ=0.
  - KILL: request outstanding, response to be discarded.
    - IMEM_REQ stays high with the old address until IMEM_ACK.
    - On IMEM_ACK: drop the data, go to IDLE, IMEM_REQ=0.
- REDIRECT=1 at an edge:
  - Flush FIFO (count=0) and set fetch_pc=REDIRECT_PC.
  - IDLE stays IDLE; the new request issues on the following edge.
  - WAIT without ack goes to KILL.
  - WAIT with ack in the same cycle: the data is discarded and the state goes to IDLE.
  - KILL stays KILL (or goes to IDLE if acked), with fetch_pc updated to the latest REDIRECT_PC.
  - A pop in the same cycle as REDIRECT is ignored.
  - INSTR_VALID=0 in the cycle after a redirect.
- FIFO:
  - Circular buffer with head/tail pointers wrapping modulo DEPTH.
  - INSTR_VALID = (count != 0). INSTR and INSTR_PC come from the head entry; they are 0-valued only after reset.
  - Simultaneous push and pop leaves count unchanged.
  - Overflow is impossible because requests only issue when space is available; underflow is impossible because pop requires INSTR_VALID.
- fetch_pc arithmetic is modulo 2^ADDR_W, so 32'hFFFF_FFFC+4 wraps to 0. REDIRECT_PC[1:0] is ignored and forced to 0.
- Latency:
  - With the queue empty and 0-wait memory, an instruction appears on INSTR one cycle after the acking edge.
  - Sustained throughput is 1 instruction/cycle when memory acks every cycle and the Core holds INSTR_READY=1.

Test Plan:
- Reset release, memory acks every cycle, INSTR_READY=1 -> IMEM_ADDR 0x0,0x4,0x8,... back-to-back; INSTR_PC matches each address; one instruction per cycle after a 2-cycle startup.
- INSTR_READY=0, 1-cycle-ack memory -> exactly 4 pushes (PCs 0x0-0xC), then IMEM_REQ=0 and INSTR_VALID held with INSTR_PC=0x0. On INSTR_READY=1, fetching resumes at 0x10 with no lost or duplicated PC.
- Memory acks 3 cycles late; REDIRECT with REDIRECT_PC=0x100 on the 2nd wait cycle -> FIFO empties; the stale ack is discarded; the next IMEM_ADDR is 0x100; the first INSTR_PC out is 0x100.
- REDIRECT in the same cycle as IMEM_ACK and INSTR_READY with 3 entries queued -> the acked word is dropped, INSTR_VALID=0 the next cycle, and the next request is to REDIRECT_PC.
- Two REDIRECTs (0x200 then 0x300) during one KILL wait -> only 0x300 is fetched afterwards.
- Redirect to 0xFFFF_FFF8 -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap). RESET_N pulsed low mid-WAIT -> IMEM_REQ drops immediately and the first post-reset IMEM_ADDR=RESET_PC.
